pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 7: program-counter width in bits.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries, a power of two and at least 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the port keeps the codebase name, and the polarity is low-true.
REQ-006 pc_wr  input  1  PC/stack update enable; low = stall.
REQ-007 j  input  1  absolute jump to j_adx.
REQ-008 jr  input  1  register jump to jr_adx.
REQ-009 br  input  1  conditional branch request.
REQ-010 z  input  1  zero flag; branch taken when br=1 and z=0.
REQ-011 call  input  1  qualifies j as a subroutine call (push return address).
REQ-012 ret  input  1  return; target popped from the stack.
REQ-013 j_adx  input  PC_W  absolute jump target.
REQ-014 jr_adx  input  PC_W  register jump target.
REQ-015 br_off  input  PC_W  two's-complement branch offset relative to the current pc.
REQ-016 pc  output  PC_W  registered current PC.
REQ-017 pc_next  output  PC_W  combinational next-PC selection.
REQ-018 ras_empty  output  1  stack holds 0 entries.
REQ-019 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-020 ras_err  output  1  sticky flag: overflow push or empty pop occurred.

Function
REQ-021 pc_next priority SHALL be, highest first: ret with a non-empty stack -> stack top; jr -> jr_adx; j -> j_adx; taken branch -> pc + br_off; otherwise pc + 1.
REQ-022 All additions SHALL be modulo 2^PC_W; pc = 2^PC_W-1 with no redirect SHALL wrap to 0, and negative br_off SHALL wrap correctly.
REQ-023 On a rising clk edge with pc_wr=1, pc SHALL load pc_next, giving a one-cycle redirect latency.
REQ-024 With pc_wr=0, pc, stack contents, pointer, count and ras_err SHALL hold; pc_next SHALL remain combinationally valid.
REQ-025 A push SHALL occur when pc_wr=1, j=1, call=1, ret=0 and jr=0; the pushed value SHALL be pc + 1 (mod 2^PC_W).
REQ-026 A pop SHALL occur when pc_wr=1, ret=1 and the stack is non-empty.
REQ-027 A push while full SHALL overwrite the oldest entry circularly, leave count at RAS_DEPTH, and set ras_err.
REQ-028 ret on an empty stack SHALL perform no pop, set ras_err, and fall through to the next priority source.
REQ-029 When call and ret are both asserted, ret SHALL win and no push SHALL occur.
REQ-030 call without j SHALL be ignored.
REQ-031 ras_err SHALL clear only on reset.

Reset
REQ-032 While reset=0, asynchronously: pc=RESET_PC, stack pointer=0, count=0, ras_empty=1, ras_full=0, ras_err=0; stack entry contents are don't-care.
REQ-033 Reset asserted mid-operation, including during a stall, SHALL override all other inputs.
REQ-034 On release, the first update SHALL occur on the first rising clk edge with reset=1.

Configuration
REQ-035 Macro PC_SEQ_RAS_EN defined: the return-address stack and REQ-025 to REQ-031 SHALL be implemented.
REQ-036 PC_SEQ_RAS_EN undefined: no stack storage SHALL be built, call and ret SHALL be ignored, ras_empty SHALL be tied to 1, ras_full to 0 and ras_err to 0; all other behaviour is unchanged.

Verification
REQ-037 Reset then 10 cycles with pc_wr=1 and no redirects -> pc steps 0..10; with PC_W=7, starting from pc=127, the next pc = 0.
REQ-038 pc=20: br=1,z=0,br_off=-5 -> pc=15; br=1,z=1 -> pc=21; jr=1,j=1,jr_adx=47,j_adx=4 -> pc=47.
REQ-039 pc=8: j=1,call=1,j_adx=30 -> pc=30 and ras_empty=0; later ret=1 -> pc=9 and ras_empty=1.
REQ-040 Five nested calls at RAS_DEPTH=4 -> ras_full=1 and ras_err=1; four rets return the four newest addresses in LIFO order; a fifth ret falls to sequential.
REQ-041 pc_wr=0 for 10 cycles with j=1 -> pc, flags and stack unchanged; reset=0 mid-stall -> pc=RESET_PC immediately, without waiting for clk.
REQ-042 Build without PC_SEQ_RAS_EN: call+j to 30 then ret -> pc=30 then pc=31; ras_empty=1 and ras_err=0 throughout.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: jump / register-jump / branch / sequential next-PC select.
// Define PC_SEQ_RAS_EN to build the return-address stack used by call/ret.
module pc_sequencer #(
  parameter int              PC_W      = 7,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_wr,
  input  logic            j,
  input  logic            jr,
  input  logic            br,
  input  logic            z,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] j_adx,
  input  logic [PC_W-1:0] jr_adx,
  input  logic [PC_W-1:0] br_off,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ras_top;
  logic            ret_hit;

  always_comb begin
    if (ret_hit)       pc_d = ras_top;
    else if (jr)       pc_d = jr_adx;
    else if (j)        pc_d = j_adx;
    else if (br && !z) pc_d = pc_q + br_off;
    else               pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     pc_q <= RESET_PC;
    else if (pc_wr) pc_q <= pc_d;
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

`ifdef PC_SEQ_RAS_EN
  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam int               CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             empty, full, push, pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign ret_hit = ret & ~empty;
  assign pop     = pc_wr & ret_hit;
  assign push    = pc_wr & j & call & ~ret & ~jr;
  // sp_q is the next free slot, so the top lives one below it
  assign ras_top = stack_q[sp_q - PTR_W'(1)];

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      // when full, sp_q already points at the oldest entry, so this overwrites it
      sp_d = sp_q + PTR_W'(1);
      if (full) err_d = 1'b1;
      else      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (pc_wr && ret && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (pc_wr) begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q] <= pc_q + PC_W'(1);
  end

  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_err   = err_q;
`else
  logic unused_ras;
  assign unused_ras = call ^ ret;
  assign ret_hit    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; expectations follow PC_SEQ_RAS_EN.
module tb_pc_sequencer;
  localparam int PC_W = 7;

  logic clk = 1'b0, reset = 1'b0;
  logic pc_wr = 1'b0, j = 1'b0, jr = 1'b0, br = 1'b0, z = 1'b0, call = 1'b0, ret = 1'b0;
  logic [PC_W-1:0] j_adx = '0, jr_adx = '0, br_off = '0;
  logic [PC_W-1:0] pc, pc_next;
  logic ras_empty, ras_full, ras_err;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(7'd0), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc_wr(pc_wr), .j(j), .jr(jr), .br(br), .z(z),
    .call(call), .ret(ret), .j_adx(j_adx), .jr_adx(jr_adx), .br_off(br_off),
    .pc(pc), .pc_next(pc_next), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  typedef struct {
    logic wr, j, jr, br, z, call, ret;
    logic [PC_W-1:0] ja, jra, off, nxt, pcx;
    logic emp, full, err;
  } vec_t;

  function automatic vec_t mk(input logic wr, jj, jjr, bb, zz, cc, rr,
                              input int ja, jra, off, nxt, pcx,
                              input logic emp, full, err);
    vec_t v;
    v.wr = wr; v.j = jj; v.jr = jjr; v.br = bb; v.z = zz; v.call = cc; v.ret = rr;
    v.ja = PC_W'(ja); v.jra = PC_W'(jra); v.off = PC_W'(off);
    v.nxt = PC_W'(nxt); v.pcx = PC_W'(pcx);
    v.emp = emp; v.full = full; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d exp=%0d", nm, idx, act, exp);
    end
  endtask

  // drive at posedge+1, check combinational pc_next, then registered state after the edge
  task automatic step(input string grp, input int idx, input vec_t v);
    pc_wr = v.wr; j = v.j; jr = v.jr; br = v.br; z = v.z; call = v.call; ret = v.ret;
    j_adx = v.ja; jr_adx = v.jra; br_off = v.off;
    #1;
    chk({grp, ".pc_next"}, idx, 32'(pc_next), 32'(v.nxt));
    @(posedge clk); #1;
    chk({grp, ".pc"}, idx, 32'(pc), 32'(v.pcx));
    chk({grp, ".empty"}, idx, 32'(ras_empty), 32'(v.emp));
    chk({grp, ".full"}, idx, 32'(ras_full), 32'(v.full));
    chk({grp, ".err"}, idx, 32'(ras_err), 32'(v.err));
  endtask

  vec_t tbl[$];
  vec_t ras[$];

  initial begin
    // common sequencing: steps, branches, priority, wrap, stall
    for (int i = 1; i <= 10; i++) tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0, i,i, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 20,0,0,  20,20,  1,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,0, 0,0,-5,  15,15,  1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 20,0,0,  20,20,  1,0,0));
    tbl.push_back(mk(1,0,0,1,1,0,0, 0,0,-5,  21,21,  1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 20,0,0,  20,20,  1,0,0));
    tbl.push_back(mk(1,1,1,0,0,0,0, 4,47,0,  47,47,  1,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,0, 0,0,100, 19,19,  1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 127,0,0, 127,127,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,   0,0,    1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 5,0,0,   5,0,    1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,0,-1,  127,0,  1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,   1,1,    1,0,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 9,0,50,  9,9,    1,0,0));

`ifdef PC_SEQ_RAS_EN
    ras.push_back(mk(1,1,0,0,0,0,0, 8,0,0,   8,8,    1,0,0));
    ras.push_back(mk(1,1,0,0,0,1,0, 30,0,0,  30,30,  0,0,0));
    ras.push_back(mk(1,0,0,0,0,0,1, 0,0,0,   9,9,    1,0,0));
    ras.push_back(mk(1,1,0,0,0,1,0, 40,0,0,  40,40,  0,0,0));
    ras.push_back(mk(1,1,0,0,0,1,0, 50,0,0,  50,50,  0,0,0));
    ras.push_back(mk(1,1,0,0,0,1,0, 60,0,0,  60,60,  0,0,0));
    ras.push_back(mk(1,1,0,0,0,1,0, 70,0,0,  70,70,  0,1,0));
    ras.push_back(mk(1,1,0,0,0,1,0, 80,0,0,  80,80,  0,1,1));
    ras.push_back(mk(1,0,0,0,0,0,1, 0,0,0,   71,71,  0,0,1));
    ras.push_back(mk(1,0,0,0,0,0,1, 0,0,0,   61,61,  0,0,1));
    ras.push_back(mk(1,0,0,0,0,0,1, 0,0,0,   51,51,  0,0,1));
    ras.push_back(mk(1,0,0,0,0,0,1, 0,0,0,   41,41,  1,0,1));
    ras.push_back(mk(1,0,0,0,0,0,1, 0,0,0,   42,42,  1,0,1));
    ras.push_back(mk(1,1,0,0,0,1,1, 100,0,0, 100,100,1,0,1));
    ras.push_back(mk(1,1,0,0,0,1,0, 90,0,0,  90,90,  0,0,1));
    for (int i = 0; i < 10; i++) ras.push_back(mk(0,1,0,0,0,1,0, 5,0,0, 5,90, 0,0,1));
    ras.push_back(mk(0,0,0,0,0,0,1, 0,0,0,   101,90, 0,0,1));
    ras.push_back(mk(1,0,0,0,0,0,1, 0,0,0,   101,101,1,0,1));
    ras.push_back(mk(1,1,0,0,0,1,0, 20,0,0,  20,20,  0,0,1));
`else
    ras.push_back(mk(1,1,0,0,0,1,0, 30,0,0,  30,30,  1,0,0));
    ras.push_back(mk(1,0,0,0,0,0,1, 0,0,0,   31,31,  1,0,0));
    for (int i = 0; i < 10; i++) ras.push_back(mk(0,1,0,0,0,1,0, 5,0,0, 5,31, 1,0,0));
    ras.push_back(mk(0,0,0,0,0,0,1, 0,0,0,   32,31,  1,0,0));
`endif

    // reset state, checked before any clock edge
    #1;
    chk("rst.pc", 0, 32'(pc), 32'd0);
    chk("rst.pc_next", 0, 32'(pc_next), 32'd1);
    chk("rst.empty", 0, 32'(ras_empty), 32'd1);
    chk("rst.full", 0, 32'(ras_full), 32'd0);
    chk("rst.err", 0, 32'(ras_err), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rel.pc", 0, 32'(pc), 32'd0);

    for (int k = 0; k < tbl.size(); k++) step("seq", k, tbl[k]);
    for (int k = 0; k < ras.size(); k++) step("ras", k, ras[k]);

    // reset mid-stall acts without a clock edge and overrides a pending write
    pc_wr = 1'b0; j = 1'b1; call = 1'b1; ret = 1'b0; j_adx = 7'd55;
    @(posedge clk); #3;
    reset = 1'b0; #1;
    chk("arst.pc", 0, 32'(pc), 32'd0);
    chk("arst.empty", 0, 32'(ras_empty), 32'd1);
    chk("arst.full", 0, 32'(ras_full), 32'd0);
    chk("arst.err", 0, 32'(ras_err), 32'd0);
    pc_wr = 1'b1;
    @(posedge clk); #1;
    chk("arst.hold_pc", 0, 32'(pc), 32'd0);
    chk("arst.hold_empty", 0, 32'(ras_empty), 32'd1);
    j = 1'b0; call = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("arst.first_pc", 0, 32'(pc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
